mult_share_arbiter: RTL and testbench

Shares one 4x4 sequential shift-add multiplier among NREQ independent requesters. Each requester has a valid/ready operand channel and a valid/ready result channel. The block selects a requester by round-robin and latches its operands. It then issues a single start pulse, tracks the multiplier's ready drop and rise, captures the 8-bit product and returns it to the granted requester. It sits between client blocks and the multiplier instance and is the only driver of the multiplier's start and operand inputs.

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/mult_share_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/mult_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OPW              = 4;
    localparam int unsigned PRODW            = 8;
    localparam int unsigned NREQ_DEFAULT     = 4;
    localparam int unsigned BUSY_TMO_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StRespond
    } arb_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester channels plus the multiplier side, as seen by the arbiter (slave) and its environment.
interface mult_share_arbiter_if #(
    parameter int unsigned NREQ = mult_arb_pkg::NREQ_DEFAULT
);
    import mult_arb_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [PRODW-1:0]    rsp_product;

    logic                mul_start;
    logic [OPW-1:0]      mul_multiplier;
    logic [OPW-1:0]      mul_multiplicand;
    logic                mul_ready;
    logic [PRODW-1:0]    mul_product;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_ready, mul_product,
        output req_ready, rsp_valid, rsp_product, mul_start, mul_multiplier, mul_multiplicand
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_ready, mul_product,
        input  req_ready, rsp_valid, rsp_product, mul_start, mul_multiplier, mul_multiplicand
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer; pointer moves past the winner on advance.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned IdxW = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] sel;
    int unsigned     pos;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        pos       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            sel = IdxW'(pos);
            if (!valid_o && req_i[sel]) begin
                valid_o    = 1'b1;
                gnt_o[sel] = 1'b1;
                gnt_idx_o  = sel;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && valid_o) begin
            ptr_d = (gnt_idx_o == IdxW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential 4x4 multiplier among NREQ requesters, one transaction in flight at a time.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned BUSY_TMO = BUSY_TMO_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 retry_err
);

    localparam int unsigned IdxW = idx_width(NREQ);
    localparam int unsigned TmoW = idx_width(BUSY_TMO);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;
    logic            accept;

    logic [IdxW-1:0]  gnt_q, gnt_d;
    logic [OPW-1:0]   a_q, a_d, b_q, b_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [PRODW-1:0] prod_q, prod_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             retry_q, retry_d;

    // Only accept while idle and the multiplier is ready, so nothing is granted while it settles.
    assign accept        = (state_q == StIdle) && bus.mul_ready && arb_valid;
    assign bus.req_ready = accept ? arb_gnt : '0;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .advance_i (accept),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .valid_o   (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        tmo_d   = tmo_q;
        prod_d  = prod_q;
        retry_d = retry_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    gnt_d   = arb_idx;
                    a_d     = bus.req_a[OPW*arb_idx +: OPW];
                    b_d     = bus.req_b[OPW*arb_idx +: OPW];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!bus.mul_ready) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoW'(BUSY_TMO - 1)) begin
                    // Start pulse was apparently missed; reissue with the same operands.
                    retry_d = 1'b1;
                    state_d = StIssue;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (bus.mul_ready) begin
                    prod_d  = bus.mul_product;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (bus.rsp_ready[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        start_d     = (state_d == StIssue);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = '0;
        if (state_d == StRespond) begin
            rsp_valid_d[gnt_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tmo_q       <= '0;
            prod_q      <= '0;
            rsp_valid_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            retry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tmo_q       <= tmo_d;
            prod_q      <= prod_d;
            rsp_valid_q <= rsp_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            retry_q     <= retry_d;
        end
    end

    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_product      = prod_q;
    assign bus.mul_start        = start_q;
    assign bus.mul_multiplier   = a_q;
    assign bus.mul_multiplicand = b_q;
    assign busy                 = busy_q;
    assign retry_err            = retry_q;

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.rsp_valid));
    a_start_single: assert property (@(posedge clk) disable iff (rst)
        start_q |=> !start_q);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, corner sequences, random scoreboard run.
module tb_mult_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, retry_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    mult_share_arbiter_if #(.NREQ(4)) bus ();

    mult_share_arbiter #(
        .NREQ     (4),
        .BUSY_TMO (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .retry_err (retry_err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: ready low while computing; optional stall ignores the start for a while.
    int         stall_len = 0;
    int         comp_len  = 3;
    logic       hold_low  = 1'b1;
    int         m_phase   = 0;
    int         m_cnt     = 0;
    logic [3:0] m_a = '0, m_b = '0;
    logic       m_rdy  = 1'b1;
    logic [7:0] m_prod = '0;

    assign bus.mul_ready   = m_rdy & ~hold_low;
    assign bus.mul_product = m_prod;

    always @(posedge clk) begin
        if (bus.mul_start) start_cnt <= start_cnt + 1;
        case (m_phase)
            0: if (bus.mul_start) begin
                m_a <= bus.mul_multiplier;
                m_b <= bus.mul_multiplicand;
                if (stall_len > 0) begin
                    m_phase <= 1;
                    m_cnt   <= stall_len;
                end else begin
                    m_rdy   <= 1'b0;
                    m_prod  <= 8'hee;
                    m_phase <= 2;
                    m_cnt   <= (comp_len == 0) ? 32'($urandom_range(1, 4)) : comp_len;
                end
            end
            1: if (m_cnt == 1) begin
                m_rdy   <= 1'b0;
                m_prod  <= 8'hee;
                m_phase <= 2;
                m_cnt   <= (comp_len == 0) ? 32'($urandom_range(1, 4)) : comp_len;
            end else begin
                m_cnt <= m_cnt - 1;
            end
            default: if (m_cnt <= 1) begin
                m_rdy   <= 1'b1;
                m_prod  <= 8'(m_a) * 8'(m_b);
                m_phase <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] r;
        r = 4'b0001 << i;
        return r;
    endfunction

    // First valid requester at or after p, wrapping; -1 when none.
    function automatic int pick(input int p, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_txn(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input int hold, input logic [3:0] side);
        int n;
        bus.req_a[4*i +: 4] = a;
        bus.req_b[4*i +: 4] = b;
        bus.req_valid[i]    = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(bus.req_ready), 32'(oh(i)));
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        @(negedge clk);
        chk("start", 32'(bus.mul_start), 32'd1);
        chk("op_a", 32'(bus.mul_multiplier), 32'(a));
        chk("op_b", 32'(bus.mul_multiplicand), 32'(b));
        chk("busy_issue", 32'(busy), 32'd1);
        @(negedge clk);
        chk("start_pulse", 32'(bus.mul_start), 32'd0);
        n = 0;
        while (bus.rsp_valid == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh(i)));
        chk("product", 32'(bus.rsp_product), 32'(exp));
        chk("busy_rsp", 32'(busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid | side;
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'(oh(i)));
            chk("hold_product", 32'(bus.rsp_product), 32'(exp));
            chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.req_valid    = bus.req_valid & ~side;
        bus.rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready[i] = 1'b0;
        @(negedge clk);
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         s0, n, ptr, cur_i, done, g;
        logic [3:0] exp_rdy, fire, cur_a, cur_b;
        bit         outst;

        vecs[0] = '{idx: 0, a: 4'd3,  b: 4'd5,  prod: 8'd15};
        vecs[1] = '{idx: 1, a: 4'd15, b: 4'd15, prod: 8'd225};
        vecs[2] = '{idx: 2, a: 4'd0,  b: 4'd9,  prod: 8'd0};
        vecs[3] = '{idx: 3, a: 4'd7,  b: 4'd8,  prod: 8'd56};
        vecs[4] = '{idx: 1, a: 4'd12, b: 4'd11, prod: 8'd132};
        vecs[5] = '{idx: 3, a: 4'd15, b: 4'd1,  prod: 8'd15};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;

        // Reset values, multiplier held not-ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_product", 32'(bus.rsp_product), 32'd0);
        chk("rst_start", 32'(bus.mul_start), 32'd0);
        chk("rst_ops", 32'({bus.mul_multiplier, bus.mul_multiplicand}), 32'd0);
        chk("rst_retry", 32'(retry_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Multiplier settling: req2 must wait for mul_ready.
        bus.req_a[11:8] = 4'd6;
        bus.req_b[11:8] = 4'd7;
        bus.req_valid[2] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("settle_no_grant", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        hold_low = 1'b0;
        do_txn(2, 4'd6, 4'd7, 8'd42, 0, 4'b0);

        // Single-transaction vector table.
        for (int v = 0; v < 6; v++) begin
            s0 = start_cnt;
            do_txn(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].prod, 0, 4'b0);
            chk("vec_one_start", 32'(start_cnt - s0), 32'd1);
        end

        // All four valid at once: pointer is 0 here, so order must be 0,1,2,3.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[4*i +: 4] = 4'(i + 1);
            bus.req_b[4*i +: 4] = 4'd15;
        end
        bus.req_valid = 4'b1111;
        for (g = 0; g < 4; g++) begin
            do_txn(g, 4'(g + 1), 4'd15, 8'((g + 1) * 15), 0, 4'b0);
        end

        // Start ignored for 6 cycles: one retry, product still correct.
        stall_len = 6;
        s0 = start_cnt;
        do_txn(0, 4'd9, 4'd3, 8'd27, 0, 4'b0);
        chk("retry_err", 32'(retry_err), 32'd1);
        chk("retry_starts", 32'(start_cnt - s0), 32'd2);
        stall_len = 0;

        // Result back-pressure with a competing request.
        do_txn(1, 4'd15, 4'd15, 8'd225, 10, 4'b0001);

        // Reset while waiting for the product.
        comp_len = 10;
        bus.req_a[3:0] = 4'd5;
        bus.req_b[3:0] = 4'd5;
        bus.req_valid[0] = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        n = 0;
        while (bus.mul_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mul_busy", 32'(bus.mul_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_start", 32'(bus.mul_start), 32'd0);
        chk("mid_ops", 32'({bus.mul_multiplier, bus.mul_multiplicand}), 32'd0);
        chk("mid_product", 32'(bus.rsp_product), 32'd0);
        chk("mid_retry", 32'(retry_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        comp_len = 3;
        bus.req_a[7:4] = 4'd9;
        bus.req_b[7:4] = 4'd9;
        bus.req_valid[1] = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.mul_ready) break;
            chk("mid_wait_grant", 32'(bus.req_ready), 32'd0);
            chk("mid_wait_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_txn(1, 4'd9, 4'd9, 8'd81, 0, 4'b0);

        // Random traffic against a transaction-level scoreboard.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        comp_len = 0;
        ptr = 0;
        outst = 1'b0;
        done = 0;
        cur_i = 0;
        cur_a = '0;
        cur_b = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_rdy = '0;
            if (!outst && bus.mul_ready && bus.req_valid != 4'b0) begin
                exp_rdy = oh(pick(ptr, bus.req_valid));
            end
            chk("rnd_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (bus.mul_start) begin
                chk("rnd_start_outst", 32'(outst), 32'd1);
                chk("rnd_op_a", 32'(bus.mul_multiplier), 32'(cur_a));
                chk("rnd_op_b", 32'(bus.mul_multiplicand), 32'(cur_b));
            end
            if (outst) begin
                if (bus.rsp_valid != 4'b0) begin
                    chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(oh(cur_i)));
                    chk("rnd_product", 32'(bus.rsp_product), 32'(8'(cur_a) * 8'(cur_b)));
                    if (bus.rsp_ready[cur_i]) begin
                        outst = 1'b0;
                        done++;
                    end
                end
            end else begin
                chk("rnd_idle_rsp", 32'(bus.rsp_valid), 32'd0);
            end
            fire = bus.req_valid & exp_rdy;
            if (fire != 4'b0) begin
                cur_i = pick(0, fire);
                cur_a = bus.req_a[4*cur_i +: 4];
                cur_b = bus.req_b[4*cur_i +: 4];
                outst = 1'b1;
                ptr   = (cur_i + 1) % 4;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i]) begin
                    bus.req_valid[i] = 1'b0;
                end else if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req_valid[i]    = 1'b1;
                        bus.req_a[4*i +: 4] = 4'($urandom);
                        bus.req_b[4*i +: 4] = 4'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = 4'($urandom);
        end
        chk("rnd_enough_done", 32'(done >= 20), 32'd1);
        bus.req_valid = '0;
        bus.rsp_ready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
